// File: rtl/alu_pkg.sv
// Shared ALU/mul-div definitions: funct codes, sequencer state enum, ALU control codes.
// Define ALU_MULDIV_DIV_EN to make FUNCT_DIVU a recognised sequencer op.
package alu_pkg;

  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_DIVU  = 6'b011011;
  localparam logic [5:0] FUNCT_ADD   = 6'b100000;
  localparam logic [5:0] FUNCT_SUB   = 6'b100010;
  localparam logic [5:0] FUNCT_AND   = 6'b100100;
  localparam logic [5:0] FUNCT_OR    = 6'b100101;

  localparam logic [3:0] ALU_CTRL_AND = 4'b0000;
  localparam logic [3:0] ALU_CTRL_OR  = 4'b0001;
  localparam logic [3:0] ALU_CTRL_ADD = 4'b0010;
  localparam logic [3:0] ALU_CTRL_SUB = 4'b0110;
  localparam logic [3:0] ALU_CTRL_SLT = 4'b0111;
  localparam logic [3:0] ALU_CTRL_NOR = 4'b1100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } muldiv_state_t;

  function automatic logic is_muldiv_funct(input logic [5:0] funct);
`ifdef ALU_MULDIV_DIV_EN
    return (funct == FUNCT_MULTU) || (funct == FUNCT_DIVU);
`else
    return (funct == FUNCT_MULTU);
`endif
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the mul/div datapath: shift-add for MULTU, restoring subtract-shift for DIVU.
// The subtract path exists only when ALU_MULDIV_DIV_EN is defined.
module muldiv_step #(
  parameter int WIDTH = 32
) (
`ifdef ALU_MULDIV_DIV_EN
  input  logic             op_div,
`endif
  input  logic [WIDTH:0]   acc,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] opnd,
  output logic [WIDTH:0]   acc_n,
  output logic [WIDTH-1:0] lo_n
);

  logic [WIDTH:0] sum;

  // acc[WIDTH] is always zero while multiplying, so the extra bit only carries
  assign sum = acc + {1'b0, (lo[0] ? opnd : {WIDTH{1'b0}})};

`ifdef ALU_MULDIV_DIV_EN
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  assign shifted = {acc[WIDTH-1:0], lo[WIDTH-1]};
  assign trial   = shifted - {1'b0, opnd};
`endif

  always_comb begin
    acc_n = {1'b0, sum[WIDTH:1]};
    lo_n  = {sum[0], lo[WIDTH-1:1]};
`ifdef ALU_MULDIV_DIV_EN
    if (op_div) begin
      // trial[WIDTH] is the sign of the trial subtraction
      if (!trial[WIDTH]) begin
        acc_n = trial;
        lo_n  = {lo[WIDTH-2:0], 1'b1};
      end else begin
        acc_n = shifted;
        lo_n  = {lo[WIDTH-2:0], 1'b0};
      end
    end
`endif
  end

endmodule

// File: rtl/alu_muldiv_seq.sv
// Iterative MULTU/DIVU sequencer beside the EX-stage ALU; stalls the pipe and writes HI/LO on completion.
// DIVU support is compiled in only when ALU_MULDIV_DIV_EN is defined.
module alu_muldiv_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [5:0]       funct_i,
  input  logic [WIDTH-1:0] rs_data_i,
  input  logic [WIDTH-1:0] rt_data_i,
  output logic             stall_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CNT_W = $clog2(WIDTH);

  muldiv_state_t state, state_n;

  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   acc, acc_n;
  logic [WIDTH-1:0] wl, wl_n;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             accept;
  logic             last;

  assign accept = start_i && ((state == IDLE) || (state == DONE)) && is_muldiv_funct(funct_i);
  assign last   = (cnt == CNT_W'(WIDTH - 1));

`ifdef ALU_MULDIV_DIV_EN
  logic is_div;
  assign is_div = (funct_i == FUNCT_DIVU);
  assign busy_o = (state == MUL) || (state == DIV);
`else
  assign busy_o = (state == MUL);
`endif

  assign stall_o = accept | busy_o;
  assign done_o  = (state == DONE);
  assign hi_o    = hi_q;
  assign lo_o    = lo_q;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
`ifdef ALU_MULDIV_DIV_EN
    .op_div (state == DIV),
`endif
    .acc    (acc),
    .lo     (wl),
    .opnd   (opnd),
    .acc_n  (acc_n),
    .lo_n   (wl_n)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_n;
  end

  // DONE always falls back to IDLE unless a new op is accepted in it
  always_comb begin
    state_n = state;
    case (state)
      IDLE, DONE: begin
        state_n = IDLE;
        if (accept) begin
`ifdef ALU_MULDIV_DIV_EN
          state_n = is_div ? DIV : MUL;
`else
          state_n = MUL;
`endif
        end
      end
      MUL: if (last) state_n = DONE;
`ifdef ALU_MULDIV_DIV_EN
      DIV: if (last) state_n = DONE;
`endif
      default: state_n = IDLE;
    endcase
  end

  // The final iteration writes straight into HI/LO so the result is visible in DONE
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt  <= '0;
      acc  <= '0;
      wl   <= '0;
      opnd <= '0;
      hi_q <= '0;
      lo_q <= '0;
    end else if (accept) begin
      cnt <= '0;
      acc <= '0;
`ifdef ALU_MULDIV_DIV_EN
      wl   <= is_div ? rs_data_i : rt_data_i;
      opnd <= is_div ? rt_data_i : rs_data_i;
`else
      wl   <= rt_data_i;
      opnd <= rs_data_i;
`endif
    end else if (busy_o) begin
      cnt <= cnt + 1'b1;
      acc <= acc_n;
      wl  <= wl_n;
      if (last) begin
        hi_q <= acc_n[WIDTH-1:0];
        lo_q <= wl_n;
      end
    end
  end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Scoreboard bench for alu_muldiv_seq: stimulus queues expected HI/LO, a monitor checks them on done_o.
// DIVU expectations follow ALU_MULDIV_DIV_EN.
module tb_alu_muldiv_seq;
  import alu_pkg::*;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [5:0]  funct;
  logic [31:0] rs;
  logic [31:0] rt;
  logic        stall, busy, done;
  logic [31:0] hi, lo;

  exp_t expQ[$];
  int   checkCount = 0;
  int   passCount  = 0;

  alu_muldiv_seq #(.WIDTH(32)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .start_i   (start),
    .funct_i   (funct),
    .rs_data_i (rs),
    .rt_data_i (rt),
    .stall_o   (stall),
    .busy_o    (busy),
    .done_o    (done),
    .hi_o      (hi),
    .lo_o      (lo)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %h, want %h", name, actual, expected);
  endtask

  task automatic applyStimulus(input logic s, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    start = s;
    funct = f;
    rs    = a;
    rt    = b;
  endtask

  task automatic pushExp(input logic [31:0] h, input logic [31:0] l);
    exp_t e;
    e.hi = h;
    e.lo = l;
    expQ.push_back(e);
  endtask

  // Called at a negedge (cycle 0); returns at the negedge of cycle 1
  task automatic issueOp(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    applyStimulus(1'b1, f, a, b);
    #1 checkOutput("stall_accept", {31'd0, stall}, 32'd1);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDone(output int cyc);
    logic stallOk;
    stallOk = 1'b1;
    cyc = 1;
    while (done !== 1'b1 && cyc < 100) begin
      if (stall !== 1'b1 || busy !== 1'b1) stallOk = 1'b0;
      @(negedge clk);
      cyc++;
    end
    if (done !== 1'b1) checkOutput("done_timeout", {31'd0, done}, 32'd1);
    checkOutput("stall_busy_run", {31'd0, stallOk}, 32'd1);
    checkOutput("stall_in_done", {31'd0, stall}, 32'd0);
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0 && done === 1'b1) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_done", {31'd0, done}, 32'd0);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("hi", hi, e.hi);
        checkOutput("lo", lo, e.lo);
        checkOutput("busy_with_done", {31'd0, busy}, 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int cyc;
    rst = 1'b1;
    applyStimulus(1'b0, 6'd0, 32'd0, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checkOutput("rst_hi", hi, 32'd0);
    checkOutput("rst_lo", lo, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_stall", {31'd0, stall}, 32'd0);

    // Non-muldiv funct is ignored
    @(negedge clk);
    applyStimulus(1'b1, FUNCT_ADD, 32'd5, 32'd6);
    #1 checkOutput("add_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    start = 1'b0;
    checkOutput("add_busy", {31'd0, busy}, 32'd0);
    checkOutput("add_done", {31'd0, done}, 32'd0);

    // Largest product
    @(negedge clk);
    pushExp(32'hFFFFFFFE, 32'h00000001);
    issueOp(FUNCT_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    waitDone(cyc);
    checkOutput("mul_max_latency", cyc, 32'd33);

`ifdef ALU_MULDIV_DIV_EN
    @(negedge clk);
    pushExp(32'd2, 32'd14);
    issueOp(FUNCT_DIVU, 32'd100, 32'd7);
    waitDone(cyc);
    checkOutput("div_latency", cyc, 32'd33);

    @(negedge clk);
    pushExp(32'h00001234, 32'hFFFFFFFF);
    issueOp(FUNCT_DIVU, 32'h00001234, 32'd0);
    waitDone(cyc);
    checkOutput("div0_latency", cyc, 32'd33);
`else
    @(negedge clk);
    applyStimulus(1'b1, FUNCT_DIVU, 32'h00001234, 32'd0);
    #1 checkOutput("divu_off_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    start = 1'b0;
    checkOutput("divu_off_busy", {31'd0, busy}, 32'd0);
    repeat (40) @(negedge clk);
    checkOutput("divu_off_hi", hi, 32'hFFFFFFFE);
    checkOutput("divu_off_lo", lo, 32'h00000001);
`endif

    // Reset in cycle 10 of a MULTU aborts with no partial result
    @(negedge clk);
    issueOp(FUNCT_MULTU, 32'h12345678, 32'd9);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    checkOutput("abort_stall", {31'd0, stall}, 32'd0);
    checkOutput("abort_done", {31'd0, done}, 32'd0);
    checkOutput("abort_hi", hi, 32'd0);
    checkOutput("abort_lo", lo, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    pushExp(32'd0, 32'd15);
    issueOp(FUNCT_MULTU, 32'd3, 32'd5);
    waitDone(cyc);
    checkOutput("mul_3x5_latency", cyc, 32'd33);

    // Back-to-back: second MULTU accepted in the first one's DONE cycle
    @(negedge clk);
    pushExp(32'h00000001, 32'h00000000);
    issueOp(FUNCT_MULTU, 32'h00010000, 32'h00010000);
    waitDone(cyc);
    checkOutput("b2b_first_latency", cyc, 32'd33);
    pushExp(32'h00000001, 32'hBD5B7DDE);
    issueOp(FUNCT_MULTU, 32'hDEADBEEF, 32'd2);
    waitDone(cyc);
    checkOutput("b2b_second_latency", cyc, 32'd33);

    repeat (3) @(negedge clk);
    checkOutput("queue_empty", expQ.size(), 32'd0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/alu_muldiv_seq.md
# alu_muldiv_seq

Iterative unsigned multiply/divide sequencer sitting beside the ALU in the EX stage. It accepts MULTU/DIVU R-type operations, runs them for a fixed number of cycles, and holds the pipeline via `stall_o` while it works. It writes the architectural HI/LO registers on completion, and these feed MFHI/MFLO.

## Interface
Parameters:
- `WIDTH`, 32, operand width; HI and LO are each `WIDTH` bits.

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `start_i`  in  1  EX-stage R-type op valid this cycle.
- `funct_i`  in  6  R-type funct field.
- `rs_data_i`  in  WIDTH  multiplicand or dividend.
- `rt_data_i`  in  WIDTH  multiplier or divisor.
- `stall_o`  out  1  freezes IF/ID/EX while an operation is being accepted or run.
- `busy_o`  out  1  state is MUL or DIV.
- `done_o`  out  1  one-cycle pulse; HI/LO are valid from this cycle.
- `hi_o`  out  WIDTH  architectural HI.
- `lo_o`  out  WIDTH  architectural LO.

## Operation
- States: IDLE, MUL, DIV, DONE. Counter `cnt` is log2(WIDTH) bits.
- Accept condition: `start_i` is high in IDLE or DONE, and `funct_i` is FUNCT_MULTU (6'b011001) or FUNCT_DIVU (6'b011011).
  - On accept, latch the operands, clear `cnt`, and go to MUL or DIV.
  - Any other funct is ignored and returns 0 on `stall_o`.
- `start_i` while in MUL or DIV is ignored. The pipeline is stalled in those states, so this only happens on protocol violation.
- MUL uses shift-add on working regs `{wh, wl}` (wl starts as rt, wh as 0) and `M` = rs.
  - Each cycle: `{c, s} = wh + (wl[0] ? M : 0)` (WIDTH+1 bits), then `{wh, wl} <= {c, s, wl} >> 1`.
- DIV uses restoring division. `rem` is WIDTH+1 bits (starts at 0), `q` starts as rs, `D` = rt.
  - Each cycle: `t = {rem[WIDTH-1:0], q[WIDTH-1]} - {1'b0, D}`.
  - If `t` is non-negative: `rem <= t` and shift in quotient bit 1.
  - Otherwise: `rem <= {rem[WIDTH-1:0], q[WIDTH-1]}` and shift in 0.
- `cnt` increments each cycle. When `cnt == WIDTH-1`, go to DONE.
- DONE lasts one cycle unless a new op is accepted.
  - On the transition into DONE, `hi_o`/`lo_o` load the result: MUL gives hi = wh, lo = wl; DIV gives hi = remainder, lo = quotient.
  - DONE then returns to IDLE, or to MUL/DIV on accept.
- Divide by zero is not special-cased. Result: lo = all ones, hi = dividend.
- `hi_o`/`lo_o` change only on entry to DONE or on reset.

## Timing
- Reset values: state IDLE, `cnt` 0, working regs 0, `hi_o` 0, `lo_o` 0, `done_o` 0, `busy_o` 0, `stall_o` 0.
- `stall_o` is combinational: `accept | busy_o`. It is high in the accept cycle so the issuing instruction holds in EX.
- Latency: accept at edge 0, then MUL/DIV for cycles 1..WIDTH, then DONE in cycle WIDTH+1.
  - `done_o` is high and new HI/LO are visible in cycle WIDTH+1 (cycle 33 for WIDTH = 32).
  - `stall_o` is low in DONE.
- Back-to-back: an accept in DONE is legal. The new op's `done_o` arrives WIDTH+1 cycles later.
- Reset asserted mid-operation aborts immediately (asynchronous). No partial result reaches HI/LO, and all outputs return to their reset values.
- `done_o` and `busy_o` are never high in the same cycle.

## Configuration
- `ALU_MULDIV_DIV_EN` defined: DIV state and restoring datapath compiled in; FUNCT_DIVU is accepted.
- Not defined: no DIV state or subtractor.
  - FUNCT_DIVU is treated as unrecognised: no stall, no done, HI/LO unchanged.
  - MULTU behaviour is identical in both builds.

## Structure
- Shared package `alu_pkg` holds:
  - FUNCT_MULTU and FUNCT_DIVU funct constants.
  - The state enum `muldiv_state_t` (IDLE/MUL/DIV/DONE).
  - ALU control codes shared with the ALU decoder.
- Sub-module `muldiv_step`: a combinational single-iteration datapath (add-shift or subtract-shift, chosen by op). The FSM, counter and HI/LO registers live in the top module.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF: `done_o` in cycle 33, hi = 0xFFFFFFFE, lo = 0x00000001, `stall_o` high in cycles 0..32.
- DIVU 100 ÷ 7 (DIV_EN build): lo = 14, hi = 2, `done_o` in cycle 33.
- DIVU 0x00001234 ÷ 0: lo = 0xFFFFFFFF, hi = 0x00001234. In the non-DIV_EN build: no stall, HI/LO unchanged.
- `start_i` with funct 6'b100000 (ADD) in IDLE: `stall_o` = 0, state stays IDLE, no `done_o`.
- Assert `rst_i` in cycle 10 of a MULTU: outputs go to reset values immediately, HI/LO read 0, and a new MULTU 3 × 5 then completes with lo = 15, hi = 0.
- MULTU accepted in a DONE cycle: first result is visible in that cycle, and the second op's `done_o` arrives 33 cycles later with the correct product.
